// File: rtl/mau_controller_pkg.sv
// Shared definitions for the MAU controller: opcodes, FSM states,
// arithmetic select codes and small decode helpers.
package mau_controller_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_COPY  = 3'b011;

    localparam logic [1:0] ARITH_ADD   = 2'd0;
    localparam logic [1:0] ARITH_SHIFT = 2'd1;
    localparam logic [1:0] ARITH_SUB   = 2'd2;
    localparam logic [1:0] ARITH_MUL   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_STORE_TAIL,
        ST_EXEC,
        ST_WRITE,
        ST_WAIT_NOP
    } state_t;

    typedef enum logic [1:0] {
        CLS_NOP,
        CLS_LOAD,
        CLS_STORE,
        CLS_EXEC
    } op_class_t;

    // COPY and all arithmetic opcodes share the EXEC/WRITE path.
    function automatic op_class_t classify(input logic [2:0] opcode);
        case (opcode)
            OP_NOP:   return CLS_NOP;
            OP_LOAD:  return CLS_LOAD;
            OP_STORE: return CLS_STORE;
            default:  return CLS_EXEC;
        endcase
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mau_controller_decode.sv
// Combinational decode of the captured instruction: copy/arith class,
// BRAM fields A and B, arithmetic select and EXEC dwell time.
module mau_controller_decode
    import mau_controller_pkg::*;
#(
    parameter int alu_latency = 1,
    parameter int mul_latency = 8
) (
    input  logic [2:0] i_opcode,
    input  logic [3:0] i_fields,
    output logic       o_is_copy,
    output logic [1:0] o_field_a,
    output logic [1:0] o_field_b,
    output logic [1:0] o_arith_sel,
    output logic [8:0] o_latency
);

    localparam logic [8:0] ALU_L = 9'(alu_latency);
    localparam logic [8:0] MUL_L = 9'(mul_latency);

    // Split fields and pick how long the datapath needs before the chunk write.
    always_comb begin
        o_field_a   = i_fields[3:2];
        o_field_b   = i_fields[1:0];
        o_is_copy   = (i_opcode == OP_COPY);
        o_arith_sel = i_opcode[1:0];
        if (o_is_copy) begin
            o_latency = 9'd1;
        end else if (o_arith_sel == ARITH_MUL) begin
            o_latency = MUL_L;
        end else begin
            o_latency = ALU_L;
        end
    end

endmodule

// File: rtl/mau_controller.sv
// MAU sequencing controller: accepts a host instruction, streams bytes
// between host and BRAM (LOAD/STORE) or runs a whole-matrix COPY/ARITH,
// then waits for the host to return to NOP.
module mau_controller
    import mau_controller_pkg::*;
#(
    parameter int matrix_dim  = 8,
    parameter int alu_latency = 1,
    parameter int mul_latency = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] host_instruction,
    input  logic [7:0] data_in,
    output logic [7:0] host_input,
    output logic [8:0] offset,
    output logic [3:0] line_wr,
    output logic [3:0] chunk_wr,
    output logic [1:0] aa_mux_sel,
    output logic [1:0] dd_mux_sel,
    output logic [1:0] arithmetic_mux_sel,
    output logic       BRAM_in_mux_sel,
    output logic       busy_flag
);

    localparam int         N      = matrix_dim * matrix_dim;
    localparam logic [8:0] LAST_K = 9'(N - 1);

    state_t     r_state, w_state_next;
    logic [8:0] r_k, w_k_next;
    logic [2:0] r_opcode;
    logic [3:0] r_fields;
    logic       r_busy;
    logic [1:0] r_aa, r_dd, r_arith;
    logic       r_bram_in;
    logic [1:0] w_aa, w_dd, w_arith;
    logic       w_bram_in;
    logic [8:0] w_offset;
    logic [3:0] w_line_wr, w_chunk_wr;

    logic       w_is_copy;
    logic [1:0] w_field_a, w_field_b, w_arith_code;
    logic [8:0] w_latency;

    // Bit 4 of the instruction carries no meaning.
    logic       w_unused_bit4;
    assign w_unused_bit4 = host_instruction[4];

    mau_controller_decode #(
        .alu_latency(alu_latency),
        .mul_latency(mul_latency)
    ) u_decode (
        .i_opcode   (r_opcode),
        .i_fields   (r_fields),
        .o_is_copy  (w_is_copy),
        .o_field_a  (w_field_a),
        .o_field_b  (w_field_b),
        .o_arith_sel(w_arith_code),
        .o_latency  (w_latency)
    );

    // State, counter, captured instruction, busy flag and held mux selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_opcode  <= OP_NOP;
            r_fields  <= '0;
            r_busy    <= 1'b0;
            r_aa      <= '0;
            r_dd      <= '0;
            r_arith   <= '0;
            r_bram_in <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_k       <= w_k_next;
            r_busy    <= (w_state_next != ST_IDLE);
            r_aa      <= w_aa;
            r_dd      <= w_dd;
            r_arith   <= w_arith;
            r_bram_in <= w_bram_in;
            if (r_state == ST_IDLE && host_instruction[7:5] != OP_NOP) begin
                r_opcode <= host_instruction[7:5];
                r_fields <= host_instruction[3:0];
            end
        end
    end

    // Next state, counter and all control outputs; selects default to their held value.
    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_offset     = '0;
        w_line_wr    = '0;
        w_chunk_wr   = '0;
        w_aa         = r_aa;
        w_dd         = r_dd;
        w_arith      = r_arith;
        w_bram_in    = r_bram_in;
        case (r_state)
            ST_IDLE: begin
                w_k_next = '0;
                case (classify(host_instruction[7:5]))
                    CLS_LOAD:  w_state_next = ST_LOAD;
                    CLS_STORE: w_state_next = ST_STORE;
                    CLS_EXEC:  w_state_next = ST_EXEC;
                    default:   w_state_next = ST_IDLE;
                endcase
            end
            ST_LOAD: begin
                w_offset  = r_k;
                w_line_wr = onehot4(w_field_a);
                if (r_k == LAST_K) begin
                    w_state_next = ST_WAIT_NOP;
                    w_k_next     = '0;
                end else begin
                    w_k_next = r_k + 9'd1;
                end
            end
            ST_STORE: begin
                w_offset = r_k;
                w_dd     = w_field_a;
                if (r_k == LAST_K) begin
                    w_state_next = ST_STORE_TAIL;
                    w_k_next     = '0;
                end else begin
                    w_k_next = r_k + 9'd1;
                end
            end
            ST_STORE_TAIL: begin
                // Last byte is still in the registered BRAM output.
                w_dd         = w_field_a;
                w_state_next = ST_WAIT_NOP;
            end
            ST_EXEC, ST_WRITE: begin
                w_aa = w_field_a;
                if (w_is_copy) begin
                    w_bram_in = 1'b1;
                end else begin
                    w_dd      = w_field_b;
                    w_arith   = w_arith_code;
                    w_bram_in = 1'b0;
                end
                if (r_state == ST_WRITE) begin
                    w_chunk_wr   = onehot4(w_field_b);
                    w_state_next = ST_WAIT_NOP;
                end else if (r_k == w_latency - 9'd1) begin
                    w_state_next = ST_WRITE;
                    w_k_next     = '0;
                end else begin
                    w_k_next = r_k + 9'd1;
                end
            end
            ST_WAIT_NOP: begin
                if (host_instruction[7:5] == OP_NOP) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_k_next     = '0;
            end
        endcase
    end

    assign host_input         = data_in;
    assign offset             = w_offset;
    assign line_wr            = w_line_wr;
    assign chunk_wr           = w_chunk_wr;
    assign aa_mux_sel         = w_aa;
    assign dd_mux_sel         = w_dd;
    assign arithmetic_mux_sel = w_arith;
    assign BRAM_in_mux_sel    = w_bram_in;
    assign busy_flag          = r_busy;

endmodule
